// File: rtl/adc_spi_capture.sv
// SPI ADC front end: frame capture, optional group averaging and a
// first-word-fall-through result FIFO feeding the register bank.
module adc_spi_capture #(
   parameter int CLK_DIV    = 4,
   parameter int ADC_BITS   = 12,
   parameter int FRAME_BITS = 16,
   parameter int AVG_LOG2   = 3,
   parameter int FIFO_AW    = 3
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             enable,
   input  logic             start_single,
   input  logic             clr_overflow,
   input  logic             adc_sdata,
   output logic             adc_cs_n,
   output logic             adc_sclk,
   output logic [15:0]      sample_data,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic [FIFO_AW:0] fifo_count,
   output logic             overflow,
   output logic             busy
);

   localparam int TW    = $clog2(2 * CLK_DIV);
   localparam int BW    = $clog2(FRAME_BITS + 1);
   localparam int ACC_W = ADC_BITS + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int GRP   = 1 << AVG_LOG2;
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      QUIET
   } state_t;

   state_t state, state_d;

   logic [TW-1:0]       tmr;
   logic                sclk_hi;
   logic [BW-1:0]       bit_cnt;
   logic [ADC_BITS-1:0] shreg;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_sum;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_inc;
   logic                single_q;

   logic                half_end;
   logic                quiet_end;
   logic                rise;
   logic                frame_end;
   logic                grp_full;
   logic                push;
   logic [15:0]         push_data;

   logic [FIFO_AW:0]    wptr;
   logic [FIFO_AW:0]    rptr;
   logic [15:0]         mem [DEPTH];
   logic                full;
   logic                pop;
   logic                wr;
   logic                drop;

   assign half_end  = (tmr == TW'(CLK_DIV - 1));
   assign quiet_end = (tmr == TW'(2 * CLK_DIV - 1));

   always_comb begin
      state_d   = state;
      rise      = 1'b0;
      frame_end = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable || start_single)
               state_d = SETUP;
         end
         SETUP: begin
            if (half_end)
               state_d = SHIFT;
         end
         SHIFT: begin
            if (half_end) begin
               if (!sclk_hi) begin
                  rise = 1'b1;
               end else if (bit_cnt == BW'(FRAME_BITS)) begin
                  frame_end = 1'b1;
                  state_d   = QUIET;
               end
            end
         end
         QUIET: begin
            if (quiet_end)
               state_d = (enable || single_q) ? SETUP : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)
         state <= IDLE;
      else
         state <= state_d;
   end

   // Shared timer: half SCLK periods in SETUP/SHIFT, full quiet gap in QUIET
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         tmr     <= '0;
         sclk_hi <= 1'b0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         if (state_d != state || state == IDLE || (state == SHIFT && half_end))
            tmr <= '0;
         else
            tmr <= tmr + 1'b1;
         if (state != SHIFT)
            sclk_hi <= 1'b0;
         else if (half_end)
            sclk_hi <= ~sclk_hi;
         if (state != SHIFT)
            bit_cnt <= '0;
         else if (rise)
            bit_cnt <= bit_cnt + 1'b1;
         if (rise)
            shreg <= {shreg[ADC_BITS-2:0], adc_sdata};
      end
   end

   assign adc_cs_n = !(state == SETUP || state == SHIFT);
   assign adc_sclk = !(state == SHIFT && !sclk_hi);
   assign busy     = (state != IDLE);

   assign acc_sum   = acc + ACC_W'(shreg);
   assign cnt_inc   = cnt + 1'b1;
   assign grp_full  = (cnt_inc == CNT_W'(GRP));
   assign push      = frame_end && grp_full;
   assign push_data = 16'(acc_sum >> AVG_LOG2);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         acc      <= '0;
         cnt      <= '0;
         single_q <= 1'b0;
      end else begin
         if (frame_end) begin
            acc <= grp_full ? '0 : acc_sum;
            cnt <= grp_full ? '0 : cnt_inc;
         end else if (state == QUIET && state_d == IDLE) begin
            acc <= '0;
            cnt <= '0;
         end
         if (state == IDLE && start_single && !enable)
            single_q <= 1'b1;
         else if (push)
            single_q <= 1'b0;
      end
   end

   assign fifo_count   = wptr - rptr;
   assign full         = fifo_count[FIFO_AW];
   assign sample_valid = (wptr != rptr);
   assign pop          = sample_valid && sample_ready;
   assign wr           = push && (!full || pop);
   assign drop         = push && full && !pop;
   assign sample_data  = mem[rptr[FIFO_AW-1:0]];

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (wr) begin
            mem[wptr[FIFO_AW-1:0]] <= push_data;
            wptr <= wptr + 1'b1;
         end
         if (pop)
            rptr <= rptr + 1'b1;
         if (drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench: ua runs without averaging, ub averages groups of 8;
// each instance has its own behavioural SPI ADC model.
module tb_adc_spi_capture;

   logic aclk  = 1'b0;
   logic rst_n = 1'b0;

   logic a_enable = 0, a_start = 0, a_clr = 0, a_ready = 0;
   logic a_sdata, a_cs_n, a_sclk, a_valid, a_ovf, a_busy;
   logic [15:0] a_data;
   logic [3:0]  a_count;

   logic b_enable = 0, b_start = 0, b_clr = 0, b_ready = 0;
   logic b_sdata, b_cs_n, b_sclk, b_valid, b_ovf, b_busy;
   logic [15:0] b_data;
   logic [3:0]  b_count;

   int checks = 0;
   int errors = 0;

   logic [15:0] a_words [16];
   logic [15:0] a_word = '0;
   int a_fp = 0, a_idx = 16;
   logic [15:0] b_words [16];
   logic [15:0] b_word = '0;
   int b_fp = 0, b_idx = 16;

   always #5 aclk = ~aclk;

   adc_spi_capture #(.AVG_LOG2(0)) ua (
      .ACLK(aclk), .ARESETN(rst_n), .enable(a_enable),
      .start_single(a_start), .clr_overflow(a_clr),
      .adc_sdata(a_sdata), .adc_cs_n(a_cs_n), .adc_sclk(a_sclk),
      .sample_data(a_data), .sample_valid(a_valid),
      .sample_ready(a_ready), .fifo_count(a_count),
      .overflow(a_ovf), .busy(a_busy)
   );

   adc_spi_capture #(.AVG_LOG2(3)) ub (
      .ACLK(aclk), .ARESETN(rst_n), .enable(b_enable),
      .start_single(b_start), .clr_overflow(b_clr),
      .adc_sdata(b_sdata), .adc_cs_n(b_cs_n), .adc_sclk(b_sclk),
      .sample_data(b_data), .sample_valid(b_valid),
      .sample_ready(b_ready), .fifo_count(b_count),
      .overflow(b_ovf), .busy(b_busy)
   );

   // ADC model: loads a word on CS fall, advances a bit after each SCLK rise
   always @(negedge a_cs_n) begin
      a_word = a_words[a_fp % 16];
      a_fp   = a_fp + 1;
      a_idx  = 0;
   end
   always @(posedge a_sclk) if (a_cs_n === 1'b0) a_idx = a_idx + 1;
   assign a_sdata = (a_idx < 16) ? a_word[4'(15 - a_idx)] : 1'b0;

   always @(negedge b_cs_n) begin
      b_word = b_words[b_fp % 16];
      b_fp   = b_fp + 1;
      b_idx  = 0;
   end
   always @(posedge b_sclk) if (b_cs_n === 1'b0) b_idx = b_idx + 1;
   assign b_sdata = (b_idx < 16) ? b_word[4'(15 - b_idx)] : 1'b0;

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge aclk);
      checks++; if (a_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got %b want 1", a_cs_n); end
      checks++; if (a_sclk !== 1'b1) begin errors++; $display("FAIL rst_sclk got %b want 1", a_sclk); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", a_busy); end
      checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", a_ovf); end
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", a_valid); end
      checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", a_count); end
      checks++; if (a_data !== 16'h0) begin errors++; $display("FAIL rst_data got %h want 0000", a_data); end
      checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rst_b_busy got %b want 0", b_busy); end
      rst_n = 1'b1;
      @(negedge aclk);
   endtask

   task automatic test_single();
      int lows = 0;
      int t;
      a_fp = 0;
      a_words[0] = 16'h0ABC;
      @(negedge aclk); a_start = 1'b1;
      @(negedge aclk); a_start = 1'b0;
      for (t = 0; t < 400 && a_busy; t++) begin
         if (!a_cs_n) lows++;
         @(negedge aclk);
      end
      checks++; if (t >= 400) begin errors++; $display("FAIL single_timeout got %0d want <400", t); end
      checks++; if (lows != 132) begin errors++; $display("FAIL single_cs_low got %0d want 132", lows); end
      checks++; if (a_idx != 16) begin errors++; $display("FAIL single_rises got %0d want 16", a_idx); end
      checks++; if (a_data !== 16'h0ABC) begin errors++; $display("FAIL single_data got %h want 0abc", a_data); end
      checks++; if (a_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", a_count); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", a_busy); end
      checks++; if (a_fp != 1) begin errors++; $display("FAIL single_frames got %0d want 1", a_fp); end
      a_ready = 1'b1;
      @(negedge aclk); a_ready = 1'b0;
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL single_pop got %b want 0", a_valid); end
   endtask

   task automatic test_mask();
      int t;
      a_fp = 0;
      a_words[0] = 16'hF123;
      @(negedge aclk); a_start = 1'b1;
      @(negedge aclk); a_start = 1'b0;
      for (t = 0; t < 400 && a_busy; t++) @(negedge aclk);
      checks++; if (a_data !== 16'h0123) begin errors++; $display("FAIL mask_data got %h want 0123", a_data); end
      a_ready = 1'b1;
      @(negedge aclk); a_ready = 1'b0;
   endtask

   task automatic test_average();
      int n;
      int t;
      b_fp = 0;
      for (int i = 0; i < 8; i++) b_words[i] = 16'(100 + i);
      @(negedge aclk); b_enable = 1'b1;
      for (t = 0; t < 10 && b_cs_n; t++) @(negedge aclk);
      for (n = 0; n < 2000 && !b_valid; n++) @(negedge aclk);
      b_enable = 1'b0;
      checks++; if (n != 1112) begin errors++; $display("FAIL avg_latency got %0d want 1112", n); end
      checks++; if (b_data !== 16'h0067) begin errors++; $display("FAIL avg_data got %h want 0067", b_data); end
      checks++; if (b_count !== 4'd1) begin errors++; $display("FAIL avg_count got %0d want 1", b_count); end
      for (t = 0; t < 100 && b_busy; t++) @(negedge aclk);
      checks++; if (b_fp != 8) begin errors++; $display("FAIL avg_frames got %0d want 8", b_fp); end
   endtask

   task automatic test_overflow();
      int t;
      a_fp = 0;
      for (int i = 0; i < 16; i++) a_words[i] = 16'(16'h0100 + i);
      @(negedge aclk); a_enable = 1'b1;
      for (t = 0; t < 1600 && !a_ovf; t++) @(negedge aclk);
      a_enable = 1'b0;
      checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", a_ovf); end
      for (t = 0; t < 100 && a_busy; t++) @(negedge aclk);
      checks++; if (a_fp != 9) begin errors++; $display("FAIL ovf_frames got %0d want 9", a_fp); end
      checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", a_count); end
      a_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (a_data !== 16'(16'h0100 + i)) begin
            errors++; $display("FAIL pop_%0d got %h want %h", i, a_data, 16'(16'h0100 + i));
         end
         @(negedge aclk);
      end
      a_ready = 1'b0;
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", a_valid); end
      checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL drain_count got %0d want 0", a_count); end
   endtask

   task automatic test_full_pop();
      int t;
      a_clr = 1'b1;
      @(negedge aclk); a_clr = 1'b0;
      checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", a_ovf); end
      a_fp = 0;
      for (int i = 0; i < 16; i++) a_words[i] = 16'(16'h0200 + i);
      a_enable = 1'b1;
      for (t = 0; t < 1300 && a_count != 4'd8; t++) @(negedge aclk);
      for (t = 0; t < 20 && !a_cs_n; t++) @(negedge aclk);
      for (t = 0; t < 20 && a_cs_n; t++) @(negedge aclk);
      repeat (131) @(negedge aclk);
      a_ready = 1'b1;
      @(negedge aclk);
      a_ready  = 1'b0;
      a_enable = 1'b0;
      checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL fullpop_count got %0d want 8", a_count); end
      checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b want 0", a_ovf); end
      checks++; if (a_data !== 16'h0201) begin errors++; $display("FAIL fullpop_head got %h want 0201", a_data); end
      for (t = 0; t < 100 && a_busy; t++) @(negedge aclk);
   endtask

   task automatic test_set_over_clear();
      int t;
      @(negedge aclk); a_start = 1'b1;
      @(negedge aclk); a_start = 1'b0;
      repeat (131) @(negedge aclk);
      a_clr = 1'b1;
      @(negedge aclk); a_clr = 1'b0;
      checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL setclr_ovf got %b want 1", a_ovf); end
      checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL setclr_count got %0d want 8", a_count); end
      checks++; if (a_data !== 16'h0201) begin errors++; $display("FAIL setclr_head got %h want 0201", a_data); end
      for (t = 0; t < 100 && a_busy; t++) @(negedge aclk);
      a_clr = 1'b1;
      @(negedge aclk); a_clr = 1'b0;
      checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL clr2_ovf got %b want 0", a_ovf); end
      a_ready = 1'b1;
      repeat (10) @(negedge aclk);
      a_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int t;
      for (int i = 0; i < 16; i++) a_words[i] = 16'h0555;
      a_enable = 1'b1;
      for (t = 0; t < 20 && a_cs_n; t++) @(negedge aclk);
      repeat (40) @(negedge aclk);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (a_cs_n !== 1'b1) begin errors++; $display("FAIL midrst_cs_n got %b want 1", a_cs_n); end
      checks++; if (a_sclk !== 1'b1) begin errors++; $display("FAIL midrst_sclk got %b want 1", a_sclk); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", a_busy); end
      repeat (3) @(negedge aclk);
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", a_valid); end
      rst_n = 1'b1;
      @(negedge aclk);
      checks++; if (a_cs_n !== 1'b0) begin errors++; $display("FAIL restart_cs_n got %b want 0", a_cs_n); end
      checks++; if (a_sclk !== 1'b1) begin errors++; $display("FAIL restart_sclk got %b want 1", a_sclk); end
      for (t = 0; t < 300 && !a_valid; t++) @(negedge aclk);
      a_enable = 1'b0;
      checks++; if (t != 132) begin errors++; $display("FAIL restart_latency got %0d want 132", t); end
      checks++; if (a_data !== 16'h0555) begin errors++; $display("FAIL restart_data got %h want 0555", a_data); end
      checks++; if (a_count !== 4'd1) begin errors++; $display("FAIL restart_count got %0d want 1", a_count); end
      for (t = 0; t < 100 && a_busy; t++) @(negedge aclk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         a_words[i] = '0;
         b_words[i] = '0;
      end
      test_reset();
      test_single();
      test_mask();
      test_average();
      test_overflow();
      test_full_pop();
      test_set_over_clear();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
